mc_controller_hs: RTL and testbench

- Next-generation multi-cycle MIPS control FSM for the MultiCycleCPU datapath.
- Adds a variable-latency memory handshake (`mem_ready`) on instruction fetch and data access.
- Adds an optional bus-timeout counter, an illegal-instruction trap, and `bne`/`jalr` support.
- Parametrised in ALUOp width and trap/timeout modes; sits between the IR (OpCode/Funct) and the datapath muxes, PC, register file and memory.

---
 rtl/mc_ctrl_pkg.sv | 20 ++
 rtl/mc_insn_decode.sv | 39 +++
 rtl/mc_controller_hs.sv | 139 +++++++++++++
 tb/tb_mc_controller_hs.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared states, opcodes, ALUOp codes and mux encodings for mc_controller_hs
package mc_ctrl_pkg;
  typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5} state_t;
  typedef enum logic [3:0] {CL_R, CL_JR, CL_JALR, CL_IALU, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_ILL} insn_class_t;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI = 6'h0C, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR = 6'h08, F_JALR = 6'h09;
  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SADD = 4'b0100, ALU_RTYPE = 4'b0011, ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0001, ALU_AND = 4'b0010, ALU_SUB = 4'b0110;
  localparam logic [1:0] PCS_SEQ = 2'b00, PCS_BR = 2'b01, PCS_J = 2'b10, PCS_EXC = 2'b11;
  localparam logic [1:0] RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10;
  localparam logic [1:0] MTR_MEM = 2'b00, MTR_ALU = 2'b01, MTR_PC = 2'b10;
  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_REG = 2'b01, SRCA_SHAMT = 2'b10;
  localparam logic [1:0] SRCB_REG = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMMSH = 2'b11;
  localparam logic [1:0] EXC_NONE = 2'b00, EXC_ILL = 2'b01, EXC_BUS = 2'b10;
  function automatic logic funct_legal(input logic [5:0] f);
    return f inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h09, [6'h20:6'h27], 6'h2A, 6'h2B};
  endfunction
endpackage

// File: rtl/mc_insn_decode.sv
// mc_insn_decode: classifies the IR opcode/funct and picks the EX-stage ALUOp
module mc_insn_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  output insn_class_t cls,
  output logic        is_shift,
  output logic        is_legal,
  output logic [3:0]  alu_op
);
  logic jump_reg;
  assign jump_reg = funct == F_JR || funct == F_JALR;
  assign is_shift = funct == F_SLL || funct == F_SRL || funct == F_SRA;
  assign is_legal = cls != CL_ILL;
  always_comb begin
    cls = CL_ILL;
    alu_op = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        cls = funct == F_JR ? CL_JR : funct == F_JALR ? CL_JALR : funct_legal(funct) ? CL_R : CL_ILL;
        alu_op = jump_reg ? ALU_ADD : ALU_RTYPE;
      end
      OP_J:     cls = CL_J;
      OP_JAL:   cls = CL_JAL;
      OP_BEQ:   begin cls = CL_BEQ;  alu_op = ALU_SUB;  end
      OP_BNE:   begin cls = CL_BNE;  alu_op = ALU_SUB;  end
      OP_ADDI:  begin cls = CL_IALU; alu_op = ALU_SADD; end
      OP_ADDIU: cls = CL_IALU;
      OP_SLTI:  begin cls = CL_IALU; alu_op = ALU_SLT;  end
      OP_SLTIU: begin cls = CL_IALU; alu_op = ALU_SLTU; end
      OP_ANDI:  begin cls = CL_IALU; alu_op = ALU_AND;  end
      OP_LUI:   cls = CL_IALU;
      OP_LW:    begin cls = CL_LW;   alu_op = ALU_SADD; end
      OP_SW:    begin cls = CL_SW;   alu_op = ALU_SADD; end
      default:  ;
    endcase
  end
endmodule

// File: rtl/mc_controller_hs.sv
// mc_controller_hs: multi-cycle MIPS control FSM with memory handshake, bus timeout and trap
module mc_controller_hs
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 4,
  parameter int EXC_EN      = 1,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         Funct,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               BranchNe,
  output logic               IorD,
  output logic               MemWrite,
  output logic               MemRead,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               ExtOp,
  output logic               LuiOp,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         RegDst,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               exc_valid,
  output logic [1:0]         exc_cause,
  output logic [2:0]         state_o
);
  state_t      state, nxt;
  insn_class_t cls;
  logic        is_shift, is_legal, timeout, bus_trap, link;
  logic [3:0]  ex_alu_op, alu4;
  logic [15:0] cnt;
  mc_insn_decode u_dec (
    .op      (OpCode),
    .funct   (Funct),
    .cls     (cls),
    .is_shift(is_shift),
    .is_legal(is_legal),
    .alu_op  (ex_alu_op)
  );
  assign timeout  = MEM_TIMEOUT != 0 && !mem_ready && cnt == 16'(MEM_TIMEOUT - 1);
  assign bus_trap = timeout && EXC_EN != 0;
  assign link     = cls == CL_JALR || cls == CL_JAL;
  assign state_o  = state;
  assign ALUOp    = ALUOP_W'(alu4);
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IF;
      cnt       <= '0;
      exc_cause <= EXC_NONE;
    end else begin
      state <= nxt;
      cnt   <= nxt != state ? '0 : (state == S_IF || state == S_MEM) && !mem_ready ? cnt + 16'd1 : cnt;
      if (nxt == S_TRAP) exc_cause <= state == S_ID ? EXC_ILL : EXC_BUS;
    end
  end
  // Outputs stay at their zero defaults while reset is held, dropping any in-flight write.
  always_comb begin
    nxt = S_IF;
    {PCWrite, PCWriteCond, BranchNe, IorD, MemWrite, MemRead, IRWrite, RegWrite, ExtOp, LuiOp, exc_valid} = '0;
    {MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource} = '0;
    alu4 = ALU_ADD;
    if (!reset) begin
      case (state)
        S_IF: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          nxt     = mem_ready ? S_ID : bus_trap ? S_TRAP : S_IF;
        end
        S_ID: begin
          ALUSrcB = SRCB_IMMSH;
          ExtOp   = 1'b1;
          nxt     = is_legal ? S_EX : EXC_EN != 0 ? S_TRAP : S_IF;
        end
        S_EX: begin
          alu4    = ex_alu_op;
          ALUSrcA = SRCA_REG;
          case (cls)
            CL_R: begin
              ALUSrcA = is_shift ? SRCA_SHAMT : SRCA_REG;
              nxt     = S_WB;
            end
            CL_JR, CL_JALR: begin
              PCWrite  = 1'b1;
              RegWrite = link;
              RegDst   = link ? RD_RD : RD_RT;
              MemtoReg = link ? MTR_PC : MTR_MEM;
            end
            CL_IALU, CL_LW, CL_SW: begin
              ALUSrcB = SRCB_IMM;
              ExtOp   = OpCode != OP_ANDI;
              LuiOp   = OpCode == OP_LUI;
              nxt     = cls == CL_IALU ? S_WB : S_MEM;
            end
            CL_BEQ, CL_BNE: begin
              PCWriteCond = 1'b1;
              PCSource    = PCS_BR;
              BranchNe    = cls == CL_BNE;
            end
            CL_J, CL_JAL: begin
              ALUSrcA  = SRCA_PC;
              PCWrite  = 1'b1;
              PCSource = PCS_J;
              RegWrite = link;
              RegDst   = link ? RD_RA : RD_RT;
              MemtoReg = link ? MTR_PC : MTR_MEM;
            end
            default: ALUSrcA = SRCA_PC;
          endcase
        end
        S_MEM: begin
          IorD     = 1'b1;
          MemRead  = cls == CL_LW;
          MemWrite = cls == CL_SW;
          nxt      = mem_ready ? (cls == CL_LW ? S_WB : S_IF) : bus_trap ? S_TRAP : S_MEM;
        end
        S_WB: begin
          RegWrite = 1'b1;
          RegDst   = cls == CL_R ? RD_RD : RD_RT;
          MemtoReg = cls == CL_LW ? MTR_MEM : MTR_ALU;
        end
        S_TRAP: begin
          PCWrite   = 1'b1;
          PCSource  = PCS_EXC;
          exc_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_controller_hs.sv
// tb_mc_controller_hs: directed checks of the handshake control FSM (trap+timeout and plain variants)
module tb_mc_controller_hs;
  logic clk = 1'b0, reset = 1'b1, mem_ready = 1'b0;
  logic [5:0] OpCode = '0, Funct = '0;
  logic PCWrite, PCWriteCond, BranchNe, IorD, MemWrite, MemRead, IRWrite, RegWrite, ExtOp, LuiOp, exc_valid;
  logic [1:0] MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource, exc_cause;
  logic [3:0] ALUOp;
  logic [2:0] state_o;
  logic n_pcw, n_pcwc, n_bne, n_iord, n_mw, n_mr, n_irw, n_rw, n_ext, n_lui, n_exv;
  logic [1:0] n_m2r, n_rd, n_sa, n_sb, n_pcs, n_cause;
  logic [3:0] n_alu;
  logic [2:0] n_state;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  mc_controller_hs #(.ALUOP_W(4), .EXC_EN(1), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .IorD(IorD),
    .MemWrite(MemWrite), .MemRead(MemRead), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ExtOp(ExtOp), .LuiOp(LuiOp), .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp), .exc_valid(exc_valid),
    .exc_cause(exc_cause), .state_o(state_o)
  );
  mc_controller_hs #(.ALUOP_W(4), .EXC_EN(0), .MEM_TIMEOUT(0)) dut_n (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
    .PCWrite(n_pcw), .PCWriteCond(n_pcwc), .BranchNe(n_bne), .IorD(n_iord),
    .MemWrite(n_mw), .MemRead(n_mr), .IRWrite(n_irw), .RegWrite(n_rw),
    .ExtOp(n_ext), .LuiOp(n_lui), .MemtoReg(n_m2r), .RegDst(n_rd), .ALUSrcA(n_sa),
    .ALUSrcB(n_sb), .PCSource(n_pcs), .ALUOp(n_alu), .exc_valid(n_exv),
    .exc_cause(n_cause), .state_o(n_state)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic adv();
    @(negedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    adv();
    chk("rst_state", state_o, 0); chk("rst_memread", MemRead, 0); chk("rst_pcwrite", PCWrite, 0);
    chk("rst_cause", exc_cause, 0); chk("rst_n_memread", n_mr, 0);
    reset = 0; OpCode = 6'h00; Funct = 6'h21; mem_ready = 1; #1;
    chk("addu_if_state", state_o, 0); chk("addu_if_memread", MemRead, 1); chk("addu_if_irw", IRWrite, 1);
    chk("addu_if_pcw", PCWrite, 1); chk("addu_if_srcb", ALUSrcB, 1);
    adv(); chk("addu_id_state", state_o, 1); chk("addu_id_srcb", ALUSrcB, 3); chk("addu_id_ext", ExtOp, 1);
    adv(); chk("addu_ex_state", state_o, 2); chk("addu_ex_aluop", ALUOp, 4'b0011);
    chk("addu_ex_srca", ALUSrcA, 1); chk("addu_ex_srcb", ALUSrcB, 0);
    adv(); chk("addu_wb_state", state_o, 4); chk("addu_wb_rw", RegWrite, 1);
    chk("addu_wb_rd", RegDst, 1); chk("addu_wb_m2r", MemtoReg, 1);
    adv(); chk("addu_back_if", state_o, 0);
    OpCode = 6'h23; mem_ready = 0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("lw_ifwait_state", state_o, 0); chk("lw_ifwait_mr", MemRead, 1); chk("lw_ifwait_irw", IRWrite, 0);
      adv();
    end
    mem_ready = 1; #1;
    chk("lw_ifrdy_state", state_o, 0); chk("lw_ifrdy_irw", IRWrite, 1); chk("lw_ifrdy_mr", MemRead, 1);
    adv(); chk("lw_id_state", state_o, 1);
    adv(); chk("lw_ex_aluop", ALUOp, 4'b0100); chk("lw_ex_srcb", ALUSrcB, 2); chk("lw_ex_srca", ALUSrcA, 1);
    adv(); mem_ready = 0; #1;
    for (int i = 0; i < 2; i++) begin
      chk("lw_memwait_state", state_o, 3); chk("lw_memwait_mr", MemRead, 1); chk("lw_memwait_iord", IorD, 1);
      adv();
    end
    mem_ready = 1; #1;
    chk("lw_memrdy_state", state_o, 3); chk("lw_memrdy_mr", MemRead, 1);
    adv(); chk("lw_wb_state", state_o, 4); chk("lw_wb_m2r", MemtoReg, 0); chk("lw_wb_rd", RegDst, 0);
    chk("lw_wb_rw", RegWrite, 1);
    adv(); chk("lw_back_if", state_o, 0);
    OpCode = 6'h05; #1;
    adv(); adv();
    chk("bne_ex_state", state_o, 2); chk("bne_ex_pcwc", PCWriteCond, 1); chk("bne_ex_bne", BranchNe, 1);
    chk("bne_ex_pcs", PCSource, 1); chk("bne_ex_aluop", ALUOp, 4'b0110); chk("bne_ex_pcw", PCWrite, 0);
    adv(); chk("bne_next_if", state_o, 0);
    OpCode = 6'h3F; #1;
    adv(); chk("ill_id_state", state_o, 1); chk("ill_id_pcw", PCWrite, 0);
    chk("ill_n_id_state", n_state, 1); chk("ill_n_id_pcw", n_pcw, 0);
    adv(); chk("ill_trap_state", state_o, 5); chk("ill_trap_exv", exc_valid, 1); chk("ill_trap_cause", exc_cause, 1);
    chk("ill_trap_pcw", PCWrite, 1); chk("ill_trap_pcs", PCSource, 3);
    chk("ill_n_state", n_state, 0); chk("ill_n_exv", n_exv, 0);
    adv(); chk("ill_after_state", state_o, 0); chk("ill_after_exv", exc_valid, 0); chk("ill_cause_held", exc_cause, 1);
    reset = 1; adv(); reset = 0; OpCode = 6'h2B; mem_ready = 1; #1;
    chk("to_rst_cause", exc_cause, 0);
    adv(); adv(); adv(); mem_ready = 0; #1;
    for (int i = 0; i < 4; i++) begin
      chk("to_mem_state", state_o, 3); chk("to_mem_mw", MemWrite, 1); adv();
    end
    chk("to_trap_state", state_o, 5); chk("to_trap_cause", exc_cause, 2); chk("to_trap_exv", exc_valid, 1);
    mem_ready = 1; adv(); chk("to_after_state", state_o, 0);
    adv(); adv(); adv(); mem_ready = 0; #1;
    chk("rmid_mem_mw", MemWrite, 1);
    adv(); reset = 1; #1;
    chk("rmid_mw", MemWrite, 0); chk("rmid_iord", IorD, 0); chk("rmid_state_before", state_o, 3);
    chk("rmid_cause_before", exc_cause, 2);
    adv(); chk("rmid_state", state_o, 0); chk("rmid_cause", exc_cause, 0);
    reset = 0; mem_ready = 1; #1;
    chk("rmid_refetch_irw", IRWrite, 1); chk("rmid_refetch_mr", MemRead, 1);
    adv(); adv(); adv(); mem_ready = 0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("race_mem_state", state_o, 3); adv();
    end
    mem_ready = 1; #1;
    chk("race_rdy_state", state_o, 3); chk("race_rdy_mw", MemWrite, 1); chk("race_rdy_exv", exc_valid, 0);
    adv(); chk("race_next_state", state_o, 0); chk("race_next_exv", exc_valid, 0); chk("race_cause", exc_cause, 0);
    OpCode = 6'h00; Funct = 6'h21; #1;
    chk("final_if_irw", IRWrite, 1);
    adv(); chk("final_id_state", state_o, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
